// File: rtl/ps2_keyboard_decoder_pkg.sv
// Shared types and Hack keyboard constants for the PS/2 keyboard decoder.
// Optional shift tracking is enabled by defining PS2_SHIFT_TRACK_EN.
package ps2_keyboard_decoder_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT       = 8'h12;
    localparam logic [7:0] PS2_RSHIFT       = 8'h59;

    localparam logic [7:0] HACK_KEY_NEWLINE   = 8'd128, HACK_KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] HACK_KEY_LEFT      = 8'd130, HACK_KEY_UP        = 8'd131;
    localparam logic [7:0] HACK_KEY_RIGHT     = 8'd132, HACK_KEY_DOWN      = 8'd133;
    localparam logic [7:0] HACK_KEY_HOME      = 8'd134, HACK_KEY_END       = 8'd135;
    localparam logic [7:0] HACK_KEY_PGUP      = 8'd136, HACK_KEY_PGDN      = 8'd137;
    localparam logic [7:0] HACK_KEY_INSERT    = 8'd138, HACK_KEY_DELETE    = 8'd139;
    localparam logic [7:0] HACK_KEY_ESC       = 8'd140, HACK_KEY_F1        = 8'd141;
    localparam logic [7:0] HACK_KEY_F12       = 8'd152;

`ifdef PS2_SHIFT_TRACK_EN
    localparam bit SHIFT_TRACK_EN = 1'b1;
`else
    localparam bit SHIFT_TRACK_EN = 1'b0;
`endif

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational PS/2 set-2 make code -> Hack keycode lookup; 0 means unmapped.
// Lower-case letters for shift=0 only when PS2_SHIFT_TRACK_EN is defined.
module ps2_scancode_map
    import ps2_keyboard_decoder_pkg::*;
(
    input  logic       ext,
    input  logic       shift,
    input  logic [7:0] scan,
    output logic [7:0] code
);

    logic [7:0] letter;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        code   = 8'd0;
        letter = 8'd0;
        if (ext) begin
            case (scan)
                8'h6B: code = HACK_KEY_LEFT;    8'h75: code = HACK_KEY_UP;
                8'h74: code = HACK_KEY_RIGHT;   8'h72: code = HACK_KEY_DOWN;
                8'h6C: code = HACK_KEY_HOME;    8'h69: code = HACK_KEY_END;
                8'h7D: code = HACK_KEY_PGUP;    8'h7A: code = HACK_KEY_PGDN;
                8'h70: code = HACK_KEY_INSERT;  8'h71: code = HACK_KEY_DELETE;
                default: code = 8'd0;
            endcase
        end else begin
            case (scan)
                8'h1C: letter = "A"; 8'h32: letter = "B"; 8'h21: letter = "C"; 8'h23: letter = "D";
                8'h24: letter = "E"; 8'h2B: letter = "F"; 8'h34: letter = "G"; 8'h33: letter = "H";
                8'h43: letter = "I"; 8'h3B: letter = "J"; 8'h42: letter = "K"; 8'h4B: letter = "L";
                8'h3A: letter = "M"; 8'h31: letter = "N"; 8'h44: letter = "O"; 8'h4D: letter = "P";
                8'h15: letter = "Q"; 8'h2D: letter = "R"; 8'h1B: letter = "S"; 8'h2C: letter = "T";
                8'h3C: letter = "U"; 8'h2A: letter = "V"; 8'h1D: letter = "W"; 8'h22: letter = "X";
                8'h35: letter = "Y"; 8'h1A: letter = "Z";
                8'h45: code = "0"; 8'h16: code = "1"; 8'h1E: code = "2"; 8'h26: code = "3";
                8'h25: code = "4"; 8'h2E: code = "5"; 8'h36: code = "6"; 8'h3D: code = "7";
                8'h3E: code = "8"; 8'h46: code = "9"; 8'h29: code = " ";
                8'h5A: code = HACK_KEY_NEWLINE; 8'h66: code = HACK_KEY_BACKSPACE;
                8'h76: code = HACK_KEY_ESC;
                8'h05: code = HACK_KEY_F1;          8'h06: code = HACK_KEY_F1 + 8'd1;
                8'h04: code = HACK_KEY_F1 + 8'd2;   8'h0C: code = HACK_KEY_F1 + 8'd3;
                8'h03: code = HACK_KEY_F1 + 8'd4;   8'h0B: code = HACK_KEY_F1 + 8'd5;
                8'h83: code = HACK_KEY_F1 + 8'd6;   8'h0A: code = HACK_KEY_F1 + 8'd7;
                8'h01: code = HACK_KEY_F1 + 8'd8;   8'h09: code = HACK_KEY_F1 + 8'd9;
                8'h78: code = HACK_KEY_F1 + 8'd10;  8'h07: code = HACK_KEY_F12;
                default: code = 8'd0;
            endcase
            if (letter != 8'd0) begin
                code = (SHIFT_TRACK_EN && !shift) ? letter + 8'd32 : letter;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, prefix handling, Hack keycode register.
// Define PS2_SHIFT_TRACK_EN to track shift keys and report lower-case letters when unshifted.
module ps2_keyboard_decoder
    import ps2_keyboard_decoder_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       frame_valid,
    output logic       frame_error
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    logic [1:0]       clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic             flt_clk_q, flt_clk_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    frame_state_e     state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d, rx_byte_q, rx_byte_d;
    logic             parity_q, parity_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             frame_valid_q, frame_valid_d, frame_error_q, frame_error_d;
    logic             ext_q, ext_d, brk_q, brk_d, shift_q, shift_d;
    logic [7:0]       keycode_q, keycode_d, map_code;
    logic             strobe, bit_in, release_hit;

    ps2_scancode_map u_map (.ext(ext_q), .shift(shift_q), .scan(rx_byte_q), .code(map_code));

`ifdef PS2_SHIFT_TRACK_EN
    logic [7:0] map_code_alt;
    ps2_scancode_map u_map_alt (.ext(ext_q), .shift(~shift_q), .scan(rx_byte_q), .code(map_code_alt));
    // A released letter may have been pressed under the other shift state.
    assign release_hit = (map_code == keycode_q) || (map_code_alt == keycode_q);
`else
    assign release_hit = (map_code == keycode_q);
`endif

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        flt_clk_d   = flt_clk_q;
        flt_cnt_d   = '0;
        if (clk_sync_q[1] != flt_clk_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                flt_clk_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
    end

    assign strobe = flt_clk_q & ~flt_clk_d;
    assign bit_in = data_sync_q[1];

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        parity_d      = parity_q;
        rx_byte_d     = rx_byte_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        to_cnt_d      = (state_q == ST_IDLE || strobe) ? '0 : to_cnt_q + TO_W'(1);
        case (state_q)
            ST_IDLE: if (strobe) begin
                if (!bit_in) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    frame_error_d = 1'b1;
                end
            end
            ST_DATA: if (strobe) begin
                shreg_d   = {bit_in, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: if (strobe) begin
                parity_d = bit_in;
                state_d  = ST_STOP;
            end
            ST_STOP: if (strobe) begin
                state_d = ST_IDLE;
                if (bit_in && (^{shreg_q, parity_q})) begin
                    frame_valid_d = 1'b1;
                    rx_byte_d     = shreg_q;
                end else begin
                    frame_error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !strobe && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d       = ST_IDLE;
            frame_error_d = 1'b1;
            to_cnt_d      = '0;
        end
    end

    // Byte interpretation runs in the cycle frame_valid is high; keycode lands one cycle later.
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        shift_d   = shift_q;
        keycode_d = keycode_q;
        if (frame_error_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (frame_valid_q) begin
            if (rx_byte_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == PS2_PREFIX_BREAK) begin
                brk_d = 1'b1;
`ifdef PS2_SHIFT_TRACK_EN
            end else if (rx_byte_q == PS2_LSHIFT || rx_byte_q == PS2_RSHIFT) begin
                shift_d = ~brk_q;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
`endif
            end else begin
                if (!brk_q && map_code != 8'd0) keycode_d = map_code;
                else if (brk_q && release_hit)  keycode_d = 8'd0;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            flt_clk_q     <= 1'b1;
            flt_cnt_q     <= '0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 8'd0;
            parity_q      <= 1'b0;
            rx_byte_q     <= 8'd0;
            to_cnt_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            shift_q       <= 1'b0;
            keycode_q     <= 8'd0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            flt_clk_q     <= flt_clk_d;
            flt_cnt_q     <= flt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            parity_q      <= parity_d;
            rx_byte_q     <= rx_byte_d;
            to_cnt_q      <= to_cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            shift_q       <= shift_d;
            keycode_q     <= keycode_d;
        end
    end

    assign keycode     = keycode_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder; honours PS2_SHIFT_TRACK_EN for letter expectations.
module tb_ps2_keyboard_decoder;

    localparam int HALF = 20;
`ifdef PS2_SHIFT_TRACK_EN
    localparam int KEY_A = 97;
`else
    localparam int KEY_A = 65;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       frame_valid, frame_error;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int fv0, fe0;

    ps2_keyboard_decoder dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .frame_valid(frame_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_error) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11);
        ps2_data = 1'b1;
        wait_cycles(4 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic mark();
        fv0 = fv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        wait_cycles(5);
        check("reset_keycode", keycode, 0);
        check("reset_valid", frame_valid, 0);
        check("reset_error", frame_error, 0);
        reset = 1'b0;
        wait_cycles(10);

        mark();
        send(8'h1C);
        check("a_valid_pulses", fv_cnt - fv0, 1);
        check("a_error_pulses", fe_cnt - fe0, 0);
        check("a_make", keycode, KEY_A);

        send(8'hF0);
        check("f0_alone", keycode, KEY_A);
        send(8'h1C);
        check("a_break", keycode, 0);

        send(8'hE0); send(8'h75);
        check("up_make", keycode, 131);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_break", keycode, 0);

        send(8'h1C);
        check("a_hold", keycode, KEY_A);
        send(8'hF0); send(8'h75);
        check("other_release", keycode, KEY_A);
        send(8'hF0); send(8'h1C);
        check("a_release", keycode, 0);

        mark();
        send_frame(8'h1C, 1'b1, 1'b0);
        check("parity_error_pulses", fe_cnt - fe0, 1);
        check("parity_no_valid", fv_cnt - fv0, 0);
        check("parity_keycode", keycode, 0);
        send(8'h5A);
        check("enter_make", keycode, 128);

        mark();
        send_bits(11'b000_0001_0100, 5);
        ps2_data = 1'b1;
        wait_cycles(19000);
        check("timeout_not_early", fe_cnt - fe0, 0);
        wait_cycles(1500);
        check("timeout_error", fe_cnt - fe0, 1);
        check("timeout_keycode", keycode, 128);
        send(8'h45);
        check("zero_after_timeout", keycode, 48);

        send(8'h05);
        check("f1_make", keycode, 141);
        send(8'h07);
        check("f12_make", keycode, 152);
        send(8'h29);
        check("space_make", keycode, 32);
        mark();
        send(8'h00);
        check("unmapped_valid", fv_cnt - fv0, 1);
        check("unmapped_keycode", keycode, 32);

        send(8'hE0);
        mark();
        send_frame(8'h75, 1'b0, 1'b1);
        check("stop_error", fe_cnt - fe0, 1);
        send(8'h75);
        check("ext_cleared_by_error", keycode, 32);
        send(8'h66);
        check("backspace_make", keycode, 129);

        mark();
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1;
        wait_cycles(40);
        check("glitch_ignored", fe_cnt - fe0, 0);
        ps2_clk = 1'b0;
        wait_cycles(8);
        ps2_clk = 1'b1;
        wait_cycles(40);
        check("bad_start_error", fe_cnt - fe0, 1);

        mark();
        send_bits(11'b000_1011_0100, 5);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(40);
        check("midframe_reset_keycode", keycode, 0);
        check("midframe_reset_no_error", fe_cnt - fe0, 0);
        send(8'h76);
        check("esc_after_reset", keycode, 140);

`ifdef PS2_SHIFT_TRACK_EN
        send(8'h12);
        check("shift_no_keycode", keycode, 140);
        send(8'h1C);
        check("shift_a_upper", keycode, 65);
        send(8'hF0); send(8'h12);
        check("shift_break_keeps", keycode, 65);
        send(8'hF0); send(8'h1C);
        check("release_either_case", keycode, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
